// File: rtl/tile_shuffler.sv
// Board-layout sequencer: free-running 16-bit Fibonacci LFSR feeding an in-place
// Fisher-Yates shuffle of 24 edge tiles, then 12 center tiles, one swap per accepted draw.
module tile_shuffler #(
  parameter int          EDGE_N   = 24,
  parameter int          CENTER_N = 12,
  parameter int          IDX_W    = 5,
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      seed_load,
  input  logic [15:0]               seed,
  output logic                      busy,
  output logic                      done,
  output logic                      order_valid,
  output logic [EDGE_N*IDX_W-1:0]   edge_order,
  output logic [CENTER_N*IDX_W-1:0] center_order
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_SHUF_E = 3'd2;
  localparam logic [2:0] S_SHUF_C = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [IDX_W-1:0] LAST_E = IDX_W'(EDGE_N - 1);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(CENTER_N - 1);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

  logic [2:0]                  state_q, state_d;
  logic [15:0]                 lfsr_q, lfsr_d;
  logic [EDGE_N*IDX_W-1:0]     work_e_q, work_e_d;
  logic [CENTER_N*IDX_W-1:0]   work_c_q, work_c_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [EDGE_N*IDX_W-1:0]     edge_q, edge_d;
  logic [CENTER_N*IDX_W-1:0]   center_q, center_d;
  logic                        valid_q, valid_d;
  logic [IDX_W-1:0]            r_e, r_c;
  logic                        fb;

  assign fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign r_e = lfsr_q[4:0];
  assign r_c = {1'b0, lfsr_q[3:0]};

  always_comb begin
    // NOTE: every _d gets a hold/default value up front, so no path leaves one unassigned (no latches).
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], fb};
    work_e_d = work_e_q;
    work_c_d = work_c_q;
    idx_d    = idx_q;
    edge_d   = edge_q;
    center_d = center_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load) lfsr_d = (seed == 16'h0000) ? SEED_RST : seed;
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        for (int k = 0; k < EDGE_N; k++)   work_e_d[k*IDX_W +: IDX_W] = IDX_W'(k);
        for (int k = 0; k < CENTER_N; k++) work_c_d[k*IDX_W +: IDX_W] = IDX_W'(k);
        idx_d   = LAST_E;
        state_d = S_SHUF_E;
      end
      S_SHUF_E: begin
        // A rejected draw (r > i) leaves everything untouched; the stepped LFSR retries next cycle.
        if (r_e <= idx_q) begin
          work_e_d[int'(idx_q)*IDX_W +: IDX_W] = work_e_q[int'(r_e)*IDX_W +: IDX_W];
          work_e_d[int'(r_e)*IDX_W +: IDX_W]   = work_e_q[int'(idx_q)*IDX_W +: IDX_W];
          if (idx_q == ONE) begin
            idx_d   = LAST_C;
            state_d = S_SHUF_C;
          end else begin
            idx_d = idx_q - ONE;
          end
        end
      end
      S_SHUF_C: begin
        if (r_c <= idx_q) begin
          work_c_d[int'(idx_q)*IDX_W +: IDX_W] = work_c_q[int'(r_c)*IDX_W +: IDX_W];
          work_c_d[int'(r_c)*IDX_W +: IDX_W]   = work_c_q[int'(idx_q)*IDX_W +: IDX_W];
          idx_d = idx_q - ONE;
          if (idx_q == ONE) begin
            state_d  = S_DONE;
            edge_d   = work_e_q;
            center_d = work_c_d;
            valid_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_RST;
      work_e_q <= '0;
      work_c_q <= '0;
      idx_q    <= '0;
      edge_q   <= '0;
      center_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      work_e_q <= work_e_d;
      work_c_q <= work_c_d;
      idx_q    <= idx_d;
      edge_q   <= edge_d;
      center_q <= center_d;
      valid_q  <= valid_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign order_valid  = valid_q;
  assign edge_order   = edge_q;
  assign center_order = center_q;

endmodule

// File: tb/tb_tile_shuffler.sv
// Directed bench for tile_shuffler: tracks the LFSR stream cycle by cycle and replays
// each shuffle through a Fisher-Yates reference to predict orders and latency.
module tb_tile_shuffler;

  localparam int          EW       = 120;
  localparam int          CW       = 60;
  localparam logic [15:0] SEED_RST = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          seed_load = 1'b0;
  logic [15:0]   seed = 16'h0000;
  logic          busy, done, order_valid;
  logic [EW-1:0] edge_order;
  logic [CW-1:0] center_order;

  int            n_checks = 0;
  int            n_errors = 0;
  bit            m_busy = 1'b0;
  logic [15:0]   m_lfsr;
  logic [EW-1:0] m_last_e = '0;
  logic [CW-1:0] m_last_c = '0;
  logic [EW-1:0] golden_e, res_e, res_e2;
  logic [CW-1:0] golden_c, res_c, res_c2;

  tile_shuffler #(.EDGE_N(24), .CENTER_N(12), .IDX_W(5), .SEED_RST(SEED_RST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed(seed),
    .busy(busy), .done(done), .order_valid(order_valid),
    .edge_order(edge_order), .center_order(center_order)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR stream: loads only when the bench knows the DUT is idle.
  always @(posedge clk) begin
    if (!rst_n)                   m_lfsr <= SEED_RST;
    else if (seed_load && !m_busy) m_lfsr <= (seed == 16'h0000) ? SEED_RST : seed;
    else                          m_lfsr <= step(m_lfsr);
  end

  function automatic void model_shuffle(input logic [15:0] l0, output logic [EW-1:0] e,
                                        output logic [CW-1:0] c, output int rej);
    int a[24];
    int b[12];
    int i, r, t;
    logic [15:0] l;
    l = l0;
    rej = 0;
    for (int k = 0; k < 24; k++) a[k] = k;
    for (int k = 0; k < 12; k++) b[k] = k;
    i = 23;
    while (i > 0) begin
      r = int'(l[4:0]);
      if (r <= i) begin t = a[i]; a[i] = a[r]; a[r] = t; i--; end
      else rej++;
      l = step(l);
    end
    i = 11;
    while (i > 0) begin
      r = int'(l[3:0]);
      if (r <= i) begin t = b[i]; b[i] = b[r]; b[r] = t; i--; end
      else rej++;
      l = step(l);
    end
    e = '0;
    c = '0;
    for (int k = 0; k < 24; k++) e[k*5 +: 5] = 5'(a[k]);
    for (int k = 0; k < 12; k++) c[k*5 +: 5] = 5'(b[k]);
  endfunction

  function automatic bit is_perm(input logic [EW-1:0] v, input int n);
    bit [31:0] seen;
    int id;
    seen = '0;
    for (int k = 0; k < n; k++) begin
      id = int'(v[k*5 +: 5]);
      if (id >= n || seen[id]) return 1'b0;
      seen[id] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic do_reset(input int n);
    m_busy = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    seed_load = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    m_last_e = '0;
    m_last_c = '0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_shuffle(input bit load, input logic [15:0] sd, input bit interfere,
                             input bit hold_chk, output logic [EW-1:0] e, output logic [CW-1:0] c);
    logic [EW-1:0] xe;
    logic [CW-1:0] xc;
    int rej, k;
    start = 1'b1;
    seed_load = load;
    seed = sd;
    @(negedge clk);
    start = 1'b0;
    seed_load = 1'b0;
    m_busy = 1'b1;
    model_shuffle(step(m_lfsr), xe, xc, rej);
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      if (hold_chk) begin
        n_checks++;
        if (edge_order !== m_last_e || center_order !== m_last_c) begin
          n_errors++;
          $display("FAIL hold k=%0d: edge %h center %h, expected edge %h center %h",
                   k, edge_order, center_order, m_last_e, m_last_c);
        end
      end
      if (interfere && k == 5) begin start = 1'b1; seed_load = 1'b1; seed = 16'hFFFF; end
      if (interfere && k == 6) begin start = 1'b0; seed_load = 1'b0; end
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k !== 35 + rej) begin
      n_errors++;
      $display("FAIL latency: done after %0d cycles, expected %0d", k, 35 + rej);
    end
    n_checks++;
    if (edge_order !== xe) begin
      n_errors++;
      $display("FAIL edge_order: got %h expected %h", edge_order, xe);
    end
    n_checks++;
    if (center_order !== xc) begin
      n_errors++;
      $display("FAIL center_order: got %h expected %h", center_order, xc);
    end
    n_checks++;
    if (order_valid !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL done_cycle flags: order_valid %b busy %b, expected 1 1", order_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL after_done: done %b busy %b, expected 0 0", done, busy);
    end
    n_checks++;
    if (edge_order !== xe || center_order !== xc) begin
      n_errors++;
      $display("FAIL orders_after_done: edge %h center %h, expected %h %h", edge_order, center_order, xe, xc);
    end
    m_busy = 1'b0;
    m_last_e = xe;
    m_last_c = xc;
    e = xe;
    c = xc;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || order_valid !== 1'b0 || edge_order !== '0 || center_order !== '0) begin
      n_errors++;
      $display("FAIL %s: busy %b done %b valid %b edge %h center %h, expected all zero",
               tag, busy, done, order_valid, edge_order, center_order);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i % 2 == 0);
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_golden();
    do_reset(2);
    seed_load = 1'b1;
    seed = 16'h1234;
    @(negedge clk);
    seed_load = 1'b0;
    run_shuffle(1'b0, 16'h0, 1'b0, 1'b0, golden_e, golden_c);
  endtask

  task automatic test_hold();
    run_shuffle(1'b0, 16'h0, 1'b0, 1'b1, res_e, res_c);
  endtask

  task automatic test_permutation();
    int gap;
    for (int n = 0; n < 200; n++) begin
      gap = int'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        seed_load = 1'b1;
        seed = 16'($urandom);
        @(negedge clk);
        seed_load = 1'b0;
      end
      repeat (gap) @(negedge clk);
      run_shuffle(1'b0, 16'h0, 1'b0, 1'b0, res_e, res_c);
      n_checks++;
      if (!is_perm(edge_order, 24) || !is_perm({60'h0, center_order}, 12) || order_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL perm run %0d: edge %h center %h valid %b", n, edge_order, center_order, order_valid);
      end
    end
  endtask

  task automatic test_seed_zero();
    do_reset(3);
    seed_load = 1'b1;
    seed = 16'h0000;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    run_shuffle(1'b0, 16'h0, 1'b0, 1'b0, res_e, res_c);
    do_reset(4);
    repeat (2) @(negedge clk);
    run_shuffle(1'b0, 16'h0, 1'b0, 1'b0, res_e2, res_c2);
    n_checks++;
    if (res_e !== res_e2 || res_c !== res_c2) begin
      n_errors++;
      $display("FAIL seed_zero: edge %h center %h, expected %h %h", res_e, res_c, res_e2, res_c2);
    end
  endtask

  task automatic test_busy_ignore();
    run_shuffle(1'b0, 16'h0, 1'b1, 1'b0, res_e, res_c);
    run_shuffle(1'b0, 16'h0, 1'b0, 1'b0, res_e2, res_c2);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_busy = 1'b1;
    repeat (14) @(negedge clk);
    m_busy = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    m_last_e = '0;
    m_last_c = '0;
    seed_load = 1'b1;
    seed = 16'h1234;
    @(negedge clk);
    seed_load = 1'b0;
    run_shuffle(1'b0, 16'h0, 1'b0, 1'b0, res_e, res_c);
    n_checks++;
    if (edge_order !== golden_e || center_order !== golden_c) begin
      n_errors++;
      $display("FAIL reproduce_golden: edge %h center %h, expected %h %h", edge_order, center_order, golden_e, golden_c);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_hold();
    test_permutation();
    test_seed_zero();
    test_busy_ignore();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
